// File: rtl/fifo_pkg.sv
// Shared async-FIFO defaults and pointer-code helpers, common to the read and write sides.
package fifo_pkg;

    localparam int unsigned PTR_WIDTH_DEF = 4;
    localparam int unsigned AE_THRESH_DEF = 2;
    localparam int unsigned CODE_W        = 32;

    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // MSB-down XOR prefix; zero-extended inputs convert correctly at any narrower width.
    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
        logic [CODE_W-1:0] b;
        b[CODE_W-1] = g[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter of configurable width.
module gray_to_bin
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = PTR_WIDTH_DEF + 1
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    assign bin_o = WIDTH'(gray2bin(CODE_W'(gray_i)));

endmodule

// File: rtl/read_ptr_module.sv
// Async-FIFO read-side pointer, empty/underflow flags and optional occupancy (macro RD_LEVEL_EN).
// Without RD_LEVEL_EN, rd_level reads 0 and almost_empty mirrors empty.
module read_ptr_module
    import fifo_pkg::*;
#(
    parameter int unsigned PTR_WIDTH = PTR_WIDTH_DEF,
    parameter int unsigned AE_THRESH = AE_THRESH_DEF
) (
    input  logic                 r_clk,
    input  logic                 r_rst,
    input  logic                 r_en,
    input  logic [PTR_WIDTH:0]   g_write_ptr_sync,
    output logic [PTR_WIDTH:0]   b_read_ptr,
    output logic [PTR_WIDTH:0]   g_read_ptr,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   rd_level,
    output logic                 underflow
);

    localparam int unsigned PW = PTR_WIDTH + 1;

    logic [PW-1:0] b_read_ptr_q, b_read_ptr_d;
    logic [PW-1:0] g_read_ptr_q, g_read_ptr_d;
    logic          empty_q, empty_d;
    logic          underflow_q, underflow_d;
    logic          rd_grant;

    // Next pointer: a read only advances while the FIFO is non-empty.
    always_comb begin
        rd_grant     = r_en & ~empty_q;
        b_read_ptr_d = b_read_ptr_q + PW'(rd_grant);
        g_read_ptr_d = PW'(bin2gray(CODE_W'(b_read_ptr_d)));
        empty_d      = (g_read_ptr_d == g_write_ptr_sync);
        underflow_d  = underflow_q | (r_en & empty_q);
    end

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            b_read_ptr_q <= '0;
            g_read_ptr_q <= '0;
            empty_q      <= 1'b1;
            underflow_q  <= 1'b0;
        end else begin
            b_read_ptr_q <= b_read_ptr_d;
            g_read_ptr_q <= g_read_ptr_d;
            empty_q      <= empty_d;
            underflow_q  <= underflow_d;
        end
    end

    assign b_read_ptr = b_read_ptr_q;
    assign g_read_ptr = g_read_ptr_q;
    assign empty      = empty_q;
    assign underflow  = underflow_q;

`ifdef RD_LEVEL_EN
    logic [PW-1:0] w_bin;
    logic [PW-1:0] rd_level_q, rd_level_d;
    logic          almost_empty_q, almost_empty_d;

    gray_to_bin #(
        .WIDTH (PW)
    ) u_wptr_g2b (
        .gray_i (g_write_ptr_sync),
        .bin_o  (w_bin)
    );

    // Occupancy uses the pointer being loaded this edge so it agrees with empty.
    always_comb begin
        rd_level_d     = w_bin - b_read_ptr_d;
        almost_empty_d = (32'(rd_level_d) <= AE_THRESH);
    end

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            rd_level_q     <= '0;
            almost_empty_q <= 1'b1;
        end else begin
            rd_level_q     <= rd_level_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign rd_level     = rd_level_q;
    assign almost_empty = almost_empty_q;
`else
    assign rd_level     = '0;
    assign almost_empty = empty_q;
`endif

endmodule

// File: tb/tb_read_ptr_module.sv
// Self-checking bench for read_ptr_module: vector table, directed corner sequences, random vs. model.
module tb_read_ptr_module;

    localparam int unsigned PW   = 5;
    localparam int          MOD  = 32;
    localparam int          AE_T = 2;

    logic          r_clk = 1'b0;
    logic          r_rst;
    logic          r_en;
    logic [PW-1:0] g_write_ptr_sync;
    logic [PW-1:0] b_read_ptr;
    logic [PW-1:0] g_read_ptr;
    logic          empty;
    logic          almost_empty;
    logic [PW-1:0] rd_level;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    read_ptr_module #(
        .PTR_WIDTH (4),
        .AE_THRESH (2)
    ) dut (
        .r_clk            (r_clk),
        .r_rst            (r_rst),
        .r_en             (r_en),
        .g_write_ptr_sync (g_write_ptr_sync),
        .b_read_ptr       (b_read_ptr),
        .g_read_ptr       (g_read_ptr),
        .empty            (empty),
        .almost_empty     (almost_empty),
        .rd_level         (rd_level),
        .underflow        (underflow)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic ren;
        int   wbin;
        int   b;
        logic emp;
        int   lvl;
        logic ae;
        logic uf;
    } vec_t;

    vec_t tbl[9];

    // Reference model state: counts reduced modulo 2^(PTR_WIDTH+1).
    int   m_rd;
    int   m_wbin;
    logic m_empty;
    logic m_uf;

    function automatic logic [PW-1:0] to_gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against explicit expectations; level/ae depend on build.
    task automatic chk_all(input string tag, input int b, input logic emp,
                           input int lvl, input logic ae, input logic uf);
        int   el;
        logic ea;
`ifdef RD_LEVEL_EN
        el = lvl;
        ea = ae;
`else
        el = 0;
        ea = emp;
`endif
        chk({tag, ".b_read_ptr"}, int'(b_read_ptr), b);
        chk({tag, ".g_read_ptr"}, int'(g_read_ptr), int'(to_gray(b)));
        chk({tag, ".empty"}, int'(empty), int'(emp));
        chk({tag, ".rd_level"}, int'(rd_level), el);
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(ea));
        chk({tag, ".underflow"}, int'(underflow), int'(uf));
    endtask

    task automatic step(input logic ren, input int wbin);
        r_en             = ren;
        g_write_ptr_sync = to_gray(wbin);
        @(posedge r_clk);
        #1;
    endtask

    // Async reset asserted between edges; outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        r_rst = 1'b1;
        #1;
        chk_all(tag, 0, 1'b1, 0, 1'b1, 1'b0);
        r_en = 1'b1;
        @(posedge r_clk);
        #1;
        chk_all({tag, "_held"}, 0, 1'b1, 0, 1'b1, 1'b0);
        r_rst   = 1'b0;
        r_en    = 1'b0;
        m_rd    = 0;
        m_wbin  = 0;
        m_empty = 1'b1;
        m_uf    = 1'b0;
    endtask

    task automatic model_edge(input logic ren);
        logic was_empty;
        was_empty = m_empty;
        if (ren && !was_empty) m_rd = (m_rd + 1) % MOD;
        m_empty = (m_rd == m_wbin);
        if (ren && was_empty) m_uf = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b0,  3, 0, 1'b0,  3, 1'b0, 1'b0};
        tbl[1] = '{1'b1,  3, 1, 1'b0,  2, 1'b1, 1'b0};
        tbl[2] = '{1'b1,  3, 2, 1'b0,  1, 1'b1, 1'b0};
        tbl[3] = '{1'b1,  3, 3, 1'b1,  0, 1'b1, 1'b0};
        tbl[4] = '{1'b1,  3, 3, 1'b1,  0, 1'b1, 1'b1};
        tbl[5] = '{1'b1,  3, 3, 1'b1,  0, 1'b1, 1'b1};
        tbl[6] = '{1'b0,  3, 3, 1'b1,  0, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 13, 3, 1'b0, 10, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 14, 4, 1'b0, 10, 1'b0, 1'b1};

        r_rst            = 1'b1;
        r_en             = 1'b0;
        g_write_ptr_sync = '0;
        #1;
        chk_all("por", 0, 1'b1, 0, 1'b1, 1'b0);
        @(posedge r_clk);
        #1;
        r_rst = 1'b0;

        // Drain, underflow stickiness, and read coinciding with a write-pointer move.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].ren, tbl[i].wbin);
            chk_all($sformatf("vec%0d", i), tbl[i].b, tbl[i].emp,
                    tbl[i].lvl, tbl[i].ae, tbl[i].uf);
        end

        // Read on to pointer 7, then reset mid-stream.
        for (int k = 5; k <= 7; k++) begin
            step(1'b1, 14);
            chk("mid.b_read_ptr", int'(b_read_ptr), k);
        end
        #2;
        do_reset("rst_mid");

        // Level tracking and the almost-empty threshold boundary.
        step(1'b0, 10);
        chk_all("lvl_load", 0, 1'b0, 10, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 10);
            if (k == 7) chk_all("lvl_r7", 7, 1'b0, 3, 1'b0, 1'b0);
        end
        chk_all("lvl_r8", 8, 1'b0, 2, 1'b1, 1'b0);

        do_reset("rst_lvl");

        // Wrap through the MSB pass.
        step(1'b0, 15);
        for (int k = 1; k <= 15; k++) step(1'b1, 15);
        chk_all("wrap_p15", 15, 1'b1, 0, 1'b1, 1'b0);
        step(1'b0, 17);
        chk_all("wrap_w17", 15, 1'b0, 2, 1'b1, 1'b0);
        step(1'b1, 17);
        chk_all("wrap_p16", 16, 1'b0, 1, 1'b1, 1'b0);
        chk("wrap_g16", int'(g_read_ptr), 24);
        step(1'b1, 17);
        chk_all("wrap_p17", 17, 1'b1, 0, 1'b1, 1'b0);
        step(1'b1, 17);
        chk_all("wrap_uf", 17, 1'b1, 0, 1'b1, 1'b1);
        step(1'b0, 17);
        chk_all("wrap_uf_hold", 17, 1'b1, 0, 1'b1, 1'b1);

        do_reset("rst_rand");

        // Random reads and writer advances against the occupancy model.
        for (int n = 0; n < 3000; n++) begin
            logic ren;
            int   occ;
            int   lvl;
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_rst");
            end else begin
                ren = 1'($urandom_range(0, 1));
                occ = (m_wbin - m_rd + MOD) % MOD;
                if (occ < 16 && $urandom_range(0, 2) != 0)
                    m_wbin = (m_wbin + 1) % MOD;
                step(ren, m_wbin);
                model_edge(ren);
                lvl = (m_wbin - m_rd + MOD) % MOD;
                chk_all("rnd", m_rd, m_empty, lvl, logic'(lvl <= AE_T), m_uf);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
